// File: rtl/vid_tx_pkg.sv
// Shared definitions for the video transmit path: controller state encoding,
// default 640x480 timing and a counter-width helper.
package vid_tx_pkg;

    // Controller states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRIME = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    // Default 640x480 timing
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Bits needed to count 0..total-1 (never narrower than one bit)
    function automatic int cnt_width(input int total);
        return (total < 2) ? 1 : $clog2(total);
    endfunction

endpackage

// File: rtl/video_timing_cnt.sv
// Horizontal/vertical position counters with wrap and region decode.
// Counting advances only while run is high; outside RUN the counters sit at 0
// because the controller only leaves RUN on the frame-wrap cycle.
module video_timing_cnt
    import vid_tx_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic active,
    output logic hsync_zone,
    output logic vsync_zone,
    output logic frame_first,
    output logic frame_last
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = cnt_width(H_TOTAL);
    localparam int VW      = cnt_width(V_TOTAL);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_LO  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_HI  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_LO  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_HI  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [HW-1:0] h_cnt_reg;
    logic [VW-1:0] v_cnt_reg;
    logic          h_wrap;

    assign h_wrap = (h_cnt_reg == H_LAST);

    // Pixel/line counters: v advances when h wraps, both wrap at frame end
    always_ff @(posedge clk) begin
        if (!rst) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
        end else if (run) begin
            if (h_wrap) begin
                h_cnt_reg <= '0;
                v_cnt_reg <= (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + 1'b1;
            end else begin
                h_cnt_reg <= h_cnt_reg + 1'b1;
            end
        end
    end

    assign active      = (h_cnt_reg < H_ACT) && (v_cnt_reg < V_ACT);
    assign hsync_zone  = (h_cnt_reg >= H_SYNC_LO) && (h_cnt_reg <= H_SYNC_HI);
    assign vsync_zone  = (v_cnt_reg >= V_SYNC_LO) && (v_cnt_reg <= V_SYNC_HI);
    assign frame_first = (h_cnt_reg == '0) && (v_cnt_reg == '0);
    assign frame_last  = h_wrap && (v_cnt_reg == V_LAST);

endmodule

// File: rtl/video_out_gen.sv
// Video output generator: pulls RGB565 pixels from a FIFO with one-cycle read
// latency and emits registered sync/de/frame_start with matching pixel data.
module video_out_gen
    import vid_tx_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        fifo_empty,
    output logic        rd_req,
    input  logic [15:0] rd_data,
    output logic        post_vs,
    output logic        post_hs,
    output logic        post_de,
    output logic [15:0] post_data,
    output logic        frame_start,
    output logic        underflow
);

    logic [1:0] state_reg, state_next;
    logic       run, de_i;
    logic       active, hsync_zone, vsync_zone, frame_first, frame_last;
    logic       rd_req_d_reg;
    logic       post_de_reg, post_hs_reg, post_vs_reg;
    logic       frame_start_reg, underflow_reg;

    assign run = (state_reg == ST_RUN);

    video_timing_cnt #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
    ) u_timing (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .active      (active),
        .hsync_zone  (hsync_zone),
        .vsync_zone  (vsync_zone),
        .frame_first (frame_first),
        .frame_last  (frame_last)
    );

    // Next-state: a running frame always finishes before returning to IDLE
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (enable) state_next = ST_PRIME;
            ST_PRIME: begin
                if (!enable)          state_next = ST_IDLE;
                else if (!fifo_empty) state_next = ST_RUN;
            end
            ST_RUN:   if (frame_last && !enable) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state_reg <= ST_IDLE;
        else      state_reg <= state_next;
    end

    assign de_i   = run && active;
    assign rd_req = de_i && !fifo_empty;

    // Output registers, one cycle behind the counters to line up with FIFO data
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_req_d_reg    <= 1'b0;
            post_de_reg     <= 1'b0;
            post_hs_reg     <= ~SYNC_POL;
            post_vs_reg     <= ~SYNC_POL;
            frame_start_reg <= 1'b0;
            underflow_reg   <= 1'b0;
        end else begin
            rd_req_d_reg    <= rd_req;
            post_de_reg     <= de_i;
            post_hs_reg     <= (run && hsync_zone) ? SYNC_POL : ~SYNC_POL;
            post_vs_reg     <= (run && vsync_zone) ? SYNC_POL : ~SYNC_POL;
            frame_start_reg <= de_i && frame_first;
            if (de_i && fifo_empty)
                underflow_reg <= 1'b1;
            else if (run && frame_first)
                underflow_reg <= 1'b0;
        end
    end

    // FIFO data arrives the cycle after the read; a suppressed read shows black
    assign post_data   = rd_req_d_reg ? rd_data : 16'h0000;
    assign post_de     = post_de_reg;
    assign post_hs     = post_hs_reg;
    assign post_vs     = post_vs_reg;
    assign frame_start = frame_start_reg;
    assign underflow   = underflow_reg;

endmodule
